// File: rtl/rv32i_top.sv
// rv32i_top: single-cycle RV32I core with integrated combinational imem and byte-lane dmem
module rv32i_top #(
  parameter int n = 32,
  parameter int depth = 1024
) (
  input logic clk,
  input logic reset_n
);
  localparam int AW = $clog2(depth);
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13, OP_REG = 7'h33;
  logic [n-1:0] imem [depth];
  logic [n-1:0] dmem [depth];
  logic [n-1:0] rf [32];
  logic [n-1:0] pc, pc4, npc, instr, rs1_v, rs2_v, alu_b, alu_y, sra, wd, addr, ld_word, ld_v, st_data;
  logic [n-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0] op, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic [3:0] st_mask;
  logic [15:0] ld_h;
  logic [7:0] ld_b;
  logic we, st, alt, lt, ltu, take, alu_ok, ld_ok;

  assign instr = imem[pc[AW+1:2]];
  assign {f7, rs2, rs1, f3, rd, op} = instr;
  assign rs1_v = rs1 == 5'd0 ? '0 : rf[rs1];
  assign rs2_v = rs2 == 5'd0 ? '0 : rf[rs2];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign pc4 = pc + 4;

  // Branches share the comparators with SLT/SLTU by routing rs2 into the B operand
  assign alu_b = (op == OP_REG || op == OP_BR) ? rs2_v : imm_i;
  assign alt = f7[5] && (op == OP_REG || f3 == 3'd5);
  assign lt = $signed(rs1_v) < $signed(alu_b);
  assign ltu = rs1_v < alu_b;
  assign sra = $unsigned($signed(rs1_v) >>> alu_b[4:0]);
  assign alu_ok = op == OP_REG ? (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) :
                  f3 == 3'd1 ? f7 == 7'h00 :
                  f3 == 3'd5 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;

  always_comb begin
    alu_y = '0;
    case (f3)
      3'd0: alu_y = alt ? rs1_v - alu_b : rs1_v + alu_b;
      3'd1: alu_y = rs1_v << alu_b[4:0];
      3'd2: alu_y = {{(n-1){1'b0}}, lt};
      3'd3: alu_y = {{(n-1){1'b0}}, ltu};
      3'd4: alu_y = rs1_v ^ alu_b;
      3'd5: alu_y = alt ? sra : rs1_v >> alu_b[4:0];
      3'd6: alu_y = rs1_v | alu_b;
      default: alu_y = rs1_v & alu_b;
    endcase
  end

  assign take = f3[2] ? ((f3[1] ? ltu : lt) ^ f3[0]) : (f3[1] ? 1'b0 : ((rs1_v == rs2_v) ^ f3[0]));

  // One adder serves load, store and JALR effective addresses
  assign addr = rs1_v + (op == OP_ST ? imm_s : imm_i);
  assign ld_word = dmem[addr[AW+1:2]];
  assign ld_h = addr[1] ? ld_word[31:16] : ld_word[15:0];
  assign ld_b = addr[0] ? ld_h[15:8] : ld_h[7:0];
  assign ld_ok = f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5;
  assign ld_v = f3 == 3'd0 ? {{24{ld_b[7]}}, ld_b} :
                f3 == 3'd1 ? {{16{ld_h[15]}}, ld_h} :
                f3 == 3'd4 ? {24'h0, ld_b} :
                f3 == 3'd5 ? {16'h0, ld_h} : ld_word;

  assign st = op == OP_ST && f3 < 3'd3;
  assign st_mask = f3 == 3'd0 ? 4'b0001 << addr[1:0] : f3 == 3'd1 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign st_data = f3 == 3'd0 ? {4{rs2_v[7:0]}} : f3 == 3'd1 ? {2{rs2_v[15:0]}} : rs2_v;

  always_comb begin
    we = 1'b0;
    wd = alu_y;
    npc = pc4;
    case (op)
      OP_LUI: begin we = 1'b1; wd = imm_u; end
      OP_AUIPC: begin we = 1'b1; wd = pc + imm_u; end
      OP_JAL: begin we = 1'b1; wd = pc4; npc = pc + imm_j; end
      OP_JALR: if (f3 == 3'd0) begin we = 1'b1; wd = pc4; npc = {addr[n-1:1], 1'b0}; end
      OP_BR: npc = take ? pc + imm_b : pc4;
      OP_LD: begin we = ld_ok; wd = ld_v; end
      OP_IMM, OP_REG: we = alu_ok;
      default: we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      pc <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      pc <= npc;
      if (we && rd != 5'd0) rf[rd] <= wd;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n && st)
      for (int i = 0; i < 4; i++)
        if (st_mask[i]) dmem[addr[AW+1:2]][8*i +: 8] <= st_data[8*i +: 8];
  end
endmodule

// File: tb/tb_rv32i_top.sv
// tb_rv32i_top: scoreboard bench running a directed RV32I program; checks are keyed to clock ticks
module tb_rv32i_top;
  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JALR = 7'h67, LD = 7'h03, IMM = 7'h13;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int tick = 0, tests = 0, fails = 0;
  typedef struct { int t; int kind; int idx; logic [31:0] exp; string name; } chk_t;
  chk_t sb[$];
  chk_t c;
  logic [31:0] act;

  rv32i_top dut (.clk(clk), .reset_n(reset_n));

  always #5 clk = ~clk;
  always @(posedge clk) tick++;

  function automatic logic [31:0] ei(int imm, int rs1, int f3, int rd, logic [6:0] op);
    logic [31:0] m = imm;
    return {m[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction
  function automatic logic [31:0] er(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] es(int imm, int rs2, int rs1, int f3);
    logic [31:0] m = imm;
    return {m[11:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] eb(int imm, int rs2, int rs1, int f3);
    logic [31:0] m = imm;
    return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:1], m[11], 7'h63};
  endfunction
  function automatic logic [31:0] eu(int imm, int rd, logic [6:0] op);
    logic [31:0] m = imm;
    return {m[19:0], 5'(rd), op};
  endfunction
  function automatic logic [31:0] ej(int imm, int rd);
    logic [31:0] m = imm;
    return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'h6f};
  endfunction

  task automatic put(int a, logic [31:0] w);
    dut.imem[a/4] = w;
  endtask
  // kind: 0 = pc, 1 = rf[idx], 2 = dmem[idx]
  task automatic expect_at(int t, int kind, int idx, logic [31:0] e, string nm);
    sb.push_back('{t, kind, idx, e, nm});
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].t <= tick) begin
      c = sb.pop_front();
      act = c.kind == 0 ? dut.pc : c.kind == 1 ? dut.rf[c.idx] : dut.dmem[c.idx];
      tests++;
      if (act !== c.exp || c.t != tick) begin
        fails++;
        $display("FAIL %s @tick %0d: got %h expected %h", c.name, tick, act, c.exp);
      end
    end
  end

  initial begin
    put(0, ei(5, 0, 0, 1, IMM));
    put(4, ei(-3, 0, 0, 2, IMM));
    put(8, er(0, 2, 1, 0, 3));
    put(12, er(32, 2, 1, 0, 4));
    put(16, er(0, 2, 1, 3, 5));
    put(20, ei(12'h401, 2, 5, 6, IMM));
    put(24, ei(7, 0, 0, 0, IMM));
    put(28, eu(32'h12345, 7, LUI));
    put(32, ei(12'h678, 7, 0, 7, IMM));
    put(36, es(12, 0, 0, 2));
    put(40, es(8, 7, 0, 2));
    put(44, ei(9, 0, 0, 8, LD));
    put(48, ei(11, 0, 4, 9, LD));
    put(52, ei(10, 0, 1, 10, LD));
    put(56, es(8, 1, 0, 0));
    put(60, eb(8, 1, 1, 0));
    put(64, ei(1, 0, 0, 13, IMM));
    put(68, eb(8, 1, 1, 1));
    put(72, ei(2, 0, 0, 14, IMM));
    put(76, ej(12, 11));
    put(80, ei(3, 0, 0, 15, IMM));
    put(84, ej(12, 0));
    put(88, ei(4, 0, 0, 16, IMM));
    put(92, ei(0, 11, 0, 0, JALR));
    put(96, ei(10, 0, 0, 17, IMM));
    put(100, ei(1, 18, 0, 18, IMM));
    put(104, ei(-1, 17, 0, 17, IMM));
    put(108, eb(-8, 0, 17, 1));
    put(112, 32'hFFFF_FFFF);
    put(116, er(0, 1, 2, 2, 19));
    put(120, eb(8, 2, 1, 6));
    put(124, ei(1, 0, 0, 20, IMM));
    put(128, es(14, 2, 0, 1));
    put(132, ei(14, 0, 1, 21, LD));
    put(136, ei(14, 0, 5, 22, LD));
    put(140, eu(1, 23, AUIPC));
    put(144, ej(0, 0));

    expect_at(2, 0, 0, 32'h0, "reset_pc");
    expect_at(2, 1, 5, 32'h0, "reset_x5");
    expect_at(3, 0, 0, 32'd4, "pc_after_1");
    expect_at(4, 0, 0, 32'd8, "pc_after_2");
    expect_at(13, 2, 2, 32'h1234_5678, "sw_word");
    expect_at(18, 0, 0, 32'd68, "beq_taken_pc");
    expect_at(21, 0, 0, 32'd88, "jal_pc");
    expect_at(21, 1, 11, 32'd80, "jal_link");
    expect_at(23, 0, 0, 32'd80, "jalr_pc");
    expect_at(57, 0, 0, 32'd116, "nop_pc");
    expect_at(70, 0, 0, 32'd144, "halt_pc");
    expect_at(70, 1, 0, 32'h0, "x0");
    expect_at(70, 1, 3, 32'd2, "add");
    expect_at(70, 1, 4, 32'd8, "sub");
    expect_at(70, 1, 5, 32'd1, "sltu");
    expect_at(70, 1, 6, 32'hFFFF_FFFE, "srai");
    expect_at(70, 1, 7, 32'h1234_5678, "lui_addi");
    expect_at(70, 1, 8, 32'h0000_0056, "lb");
    expect_at(70, 1, 9, 32'h0000_0012, "lbu");
    expect_at(70, 1, 10, 32'h0000_1234, "lh");
    expect_at(70, 2, 2, 32'h1234_5605, "sb_lane");
    expect_at(70, 1, 13, 32'h0, "beq_skip");
    expect_at(70, 1, 14, 32'd2, "bne_fall");
    expect_at(70, 1, 15, 32'd3, "after_ret");
    expect_at(70, 1, 16, 32'd4, "jal_target");
    expect_at(70, 1, 17, 32'h0, "loop_cnt");
    expect_at(70, 1, 18, 32'd10, "loop_iters");
    expect_at(70, 1, 31, 32'h0, "nop_no_write");
    expect_at(70, 1, 19, 32'd1, "slt");
    expect_at(70, 1, 20, 32'h0, "bltu_skip");
    expect_at(70, 1, 21, 32'hFFFF_FFFD, "lh_neg");
    expect_at(70, 1, 22, 32'h0000_FFFD, "lhu");
    expect_at(70, 2, 3, 32'hFFFD_0000, "sh_lane");
    expect_at(70, 1, 23, 32'h0000_108C, "auipc");
    expect_at(71, 0, 0, 32'h0, "midreset_pc");
    expect_at(71, 1, 7, 32'h0, "midreset_rf");
    expect_at(71, 2, 3, 32'hFFFD_0000, "midreset_nostore");
    expect_at(72, 0, 0, 32'd4, "restart_pc");

    while (tick < 2) @(negedge clk);
    reset_n = 1'b0;
    while (tick < 70) @(negedge clk);
    put(144, es(12, 7, 0, 2));
    reset_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL pending: %0d checks never reached, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
